// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-unit result queues feeding a round-robin scheduled,
// registered common data bus for the Tomasulo core. Each functional unit
// (0=arith, 1=logic, 2=mpy) pushes results into a small FIFO. One queue head
// per cycle is broadcast on the CDB to the reservation stations, the
// register-status table and the ROB. A synchronous flush drops everything
// queued or in flight when the ROB recovers.
module cdb_arbiter #(
    parameter int REQ_N   = 3,
    parameter int Q_N     = 2,
    parameter int TAG_W   = 5,
    parameter int REG_W   = 5,
    parameter int WORD_W  = 32,
    parameter int ROBID_W = 5,
    localparam int SRC_W  = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [REQ_N-1:0]           fu_vld,
    output logic [REQ_N-1:0]           fu_rdy,
    input  logic [REQ_N*TAG_W-1:0]     fu_tag,
    input  logic [REQ_N*REG_W-1:0]     fu_wa,
    input  logic [REQ_N*WORD_W-1:0]    fu_wdata,
    input  logic [REQ_N*ROBID_W-1:0]   fu_robid,
    output logic                       cdb_vld,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [REG_W-1:0]           cdb_wa,
    output logic [WORD_W-1:0]          cdb_wdata,
    output logic [ROBID_W-1:0]         cdb_robid,
    output logic [SRC_W-1:0]           cdb_src
);

    localparam int PTR_W = $clog2(Q_N);
    localparam int CNT_W = $clog2(Q_N + 1);

    // One queued result, exactly the fields that travel on the CDB.
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [REG_W-1:0]   wa;
        logic [WORD_W-1:0]  wdata;
        logic [ROBID_W-1:0] robid;
    } entry_t;

    // Queue storage and bookkeeping.
    entry_t           mem    [REQ_N][Q_N];
    logic [PTR_W-1:0] wr_ptr [REQ_N];
    logic [PTR_W-1:0] rd_ptr [REQ_N];
    logic [CNT_W-1:0] occ    [REQ_N];

    // Per-unit views of the flattened input buses and of the queue heads.
    entry_t           in_ent [REQ_N];
    entry_t           head   [REQ_N];

    logic [REQ_N-1:0] full;
    logic [REQ_N-1:0] cand;
    logic [REQ_N-1:0] push;
    logic [REQ_N-1:0] pop;

    // Scheduler state and decision.
    logic [SRC_W-1:0] rr_ptr;
    logic             grant;
    logic [SRC_W-1:0] winner;

    // Unpack the per-unit input fields and derive queue status flags.
    // NOTE: every always_comb output gets a value on every path (here by
    // construction, elsewhere by a default at the top) so no latch is inferred.
    always_comb begin
        for (int i = 0; i < REQ_N; i++) begin
            in_ent[i].tag   = fu_tag[i*TAG_W +: TAG_W];
            in_ent[i].wa    = fu_wa[i*REG_W +: REG_W];
            in_ent[i].wdata = fu_wdata[i*WORD_W +: WORD_W];
            in_ent[i].robid = fu_robid[i*ROBID_W +: ROBID_W];
            head[i]         = mem[i][rd_ptr[i]];
            full[i]         = (occ[i] == CNT_W'(Q_N));
            cand[i]         = (occ[i] != '0);
        end
    end

    // Ready depends only on registered occupancy, flush and reset, never on
    // fu_vld; a pop in this cycle does not free a full queue until next cycle.
    assign fu_rdy = rst_n ? (~full & {REQ_N{~flush}}) : '0;
    assign push   = fu_vld & fu_rdy;

    // Round-robin search: first non-empty queue at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < REQ_N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= REQ_N) begin
                idx = idx - REQ_N;
            end
            if (!grant && cand[idx]) begin
                grant  = 1'b1;
                winner = SRC_W'(idx);
            end
        end
    end

    // Pop the winner's head; a flush discards the grant along with the queues.
    always_comb begin
        pop = '0;
        if (grant && !flush) begin
            pop[winner] = 1'b1;
        end
    end

    // Queue pointers and occupancy; flush clears every queue at once.
    // NOTE: sequential state is assigned with <= only, so every register
    // samples the pre-edge values of its neighbours regardless of code order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < REQ_N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < REQ_N; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   occ[i] <= occ[i] + CNT_W'(1);
                    2'b01:   occ[i] <= occ[i] - CNT_W'(1);
                    default: occ[i] <= occ[i];
                endcase
            end
        end
    end

    // Queue storage writes on an accepted push.
    // NOTE: the storage array has no reset; occupancy and pointers alone
    // decide which entries are meaningful, so stale contents are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_N; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_ent[i];
            end
        end
    end

    // Registered CDB and round-robin pointer; flush outranks a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_vld   <= 1'b0;
            cdb_tag   <= '0;
            cdb_wa    <= '0;
            cdb_wdata <= '0;
            cdb_robid <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_vld   <= 1'b0;
        end else if (grant) begin
            cdb_vld   <= 1'b1;
            cdb_tag   <= head[winner].tag;
            cdb_wa    <= head[winner].wa;
            cdb_wdata <= head[winner].wdata;
            cdb_robid <= head[winner].robid;
            cdb_src   <= winner;
            rr_ptr    <= (winner == SRC_W'(REQ_N - 1)) ? '0 : winner + SRC_W'(1);
        end else begin
            cdb_vld   <= 1'b0;
        end
    end

    // A queue never accepts a push while it is full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(|(push & full)));

    // Every broadcast came from a queue that held data the cycle before.
    a_src_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
        cdb_vld |-> ((($past(cand) >> cdb_src) & REQ_N'(1)) != '0));

    // The scheduler pointer always names a real requester.
    a_rr_range: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, rr_ptr} < (SRC_W + 1)'(REQ_N)));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter. Inputs change and outputs
// are sampled just after the falling edge, away from the rising clock edge.
module tb_cdb_arbiter;

    localparam int REQ_N   = 3;
    localparam int TAG_W   = 5;
    localparam int REG_W   = 5;
    localparam int WORD_W  = 32;
    localparam int ROBID_W = 5;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [REQ_N-1:0]         fu_vld;
    logic [REQ_N-1:0]         fu_rdy;
    logic [REQ_N*TAG_W-1:0]   fu_tag;
    logic [REQ_N*REG_W-1:0]   fu_wa;
    logic [REQ_N*WORD_W-1:0]  fu_wdata;
    logic [REQ_N*ROBID_W-1:0] fu_robid;
    logic                     cdb_vld;
    logic [TAG_W-1:0]         cdb_tag;
    logic [REG_W-1:0]         cdb_wa;
    logic [WORD_W-1:0]        cdb_wdata;
    logic [ROBID_W-1:0]       cdb_robid;
    logic [1:0]               cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fu_vld    (fu_vld),
        .fu_rdy    (fu_rdy),
        .fu_tag    (fu_tag),
        .fu_wa     (fu_wa),
        .fu_wdata  (fu_wdata),
        .fu_robid  (fu_robid),
        .cdb_vld   (cdb_vld),
        .cdb_tag   (cdb_tag),
        .cdb_wa    (cdb_wa),
        .cdb_wdata (cdb_wdata),
        .cdb_robid (cdb_robid),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound.
    initial begin
        #20000;
        $display("FAIL watchdog: observed no end of test, required finish before 20000");
        $fatal(1, "time bound expired");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_cdb(input string name, input int tag, input int wa,
                             input logic [31:0] data, input int rob, input int src);
        check({name, "_vld"},   64'(cdb_vld),   64'd1);
        check({name, "_tag"},   64'(cdb_tag),   64'(tag));
        check({name, "_wa"},    64'(cdb_wa),    64'(wa));
        check({name, "_wdata"}, 64'(cdb_wdata), 64'(data));
        check({name, "_robid"}, 64'(cdb_robid), 64'(rob));
        check({name, "_src"},   64'(cdb_src),   64'(src));
    endtask

    // Advance past one rising edge and settle just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        fu_vld = '0;
    endtask

    task automatic drive(input int u, input int tag, input int wa,
                         input logic [31:0] data, input int rob);
        fu_vld[u]                   = 1'b1;
        fu_tag[u*TAG_W +: TAG_W]    = TAG_W'(tag);
        fu_wa[u*REG_W +: REG_W]     = REG_W'(wa);
        fu_wdata[u*WORD_W +: WORD_W] = data;
        fu_robid[u*ROBID_W +: ROBID_W] = ROBID_W'(rob);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [2:0] acc;
        logic [2:0] rdy_exp [4];
        int         seq [3];
        int         s;
        int         q;

        rst_n    = 1'b0;
        flush    = 1'b0;
        fu_vld   = '0;
        fu_tag   = '0;
        fu_wa    = '0;
        fu_wdata = '0;
        fu_robid = '0;

        // Reset state.
        tick();
        check("rst_rdy",   64'(fu_rdy),    64'd0);
        check("rst_vld",   64'(cdb_vld),   64'd0);
        check("rst_tag",   64'(cdb_tag),   64'd0);
        check("rst_wdata", 64'(cdb_wdata), 64'd0);
        check("rst_src",   64'(cdb_src),   64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_rdy", 64'(fu_rdy), 64'h7);

        // Single result from arith.
        drive(0, 5'h03, 7, 32'hDEADBEEF, 4);
        tick();
        idle();
        check("t1_inq_vld", 64'(cdb_vld), 64'd0);
        check("t1_inq_rdy", 64'(fu_rdy),  64'h7);
        tick();
        check_cdb("t1", 3, 7, 32'hDEADBEEF, 4, 0);
        tick();
        check("t1_after_vld", 64'(cdb_vld), 64'd0);
        check("t1_hold_tag",  64'(cdb_tag), 64'd3);

        // Contention from rr_ptr=0.
        do_reset();
        drive(0, 1, 1, 32'h1111, 1);
        drive(1, 2, 2, 32'h2222, 2);
        drive(2, 3, 3, 32'h3333, 3);
        tick();
        idle();
        check("t2_inq_vld", 64'(cdb_vld), 64'd0);
        tick();
        check_cdb("t2_g0", 1, 1, 32'h1111, 1, 0);
        tick();
        check_cdb("t2_g1", 2, 2, 32'h2222, 2, 1);
        tick();
        check_cdb("t2_g2", 3, 3, 32'h3333, 3, 2);
        // rr_ptr back at 0: arith must beat logic.
        drive(0, 4, 4, 32'h4444, 4);
        drive(1, 5, 5, 32'h5555, 5);
        tick();
        idle();
        check("t2_gap_vld", 64'(cdb_vld), 64'd0);
        tick();
        check_cdb("t2_rr0_a", 4, 4, 32'h4444, 4, 0);
        tick();
        check_cdb("t2_rr0_b", 5, 5, 32'h5555, 5, 1);
        tick();
        check("t2_end_vld", 64'(cdb_vld), 64'd0);

        // Pointer rotation: two logic results, then arith and mpy together.
        do_reset();
        drive(1, 10, 10, 32'hA0, 10);
        tick();
        drive(1, 11, 11, 32'hA1, 11);
        check("t3_inq_vld", 64'(cdb_vld), 64'd0);
        tick();
        idle();
        check_cdb("t3_l0", 10, 10, 32'hA0, 10, 1);
        check("t3_rdy", 64'(fu_rdy), 64'h7);
        tick();
        check_cdb("t3_l1", 11, 11, 32'hA1, 11, 1);
        drive(0, 12, 12, 32'hA2, 12);
        drive(2, 13, 13, 32'hA3, 13);
        tick();
        idle();
        check("t3_gap_vld", 64'(cdb_vld), 64'd0);
        tick();
        check_cdb("t3_mpy_first", 13, 13, 32'hA3, 13, 2);
        tick();
        check_cdb("t3_arith_next", 12, 12, 32'hA2, 12, 0);
        tick();
        check("t3_end_vld", 64'(cdb_vld), 64'd0);

        // Backpressure: all three units stream with valid/ready handshakes.
        do_reset();
        rdy_exp[0] = 3'b111;
        rdy_exp[1] = 3'b001;
        rdy_exp[2] = 3'b010;
        rdy_exp[3] = 3'b100;
        seq[0] = 0;
        seq[1] = 0;
        seq[2] = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k <= 9) begin
                acc = fu_rdy;
                for (int u = 0; u < 3; u++) begin
                    drive(u, u*8 + seq[u], u + 1, 32'hB000_0000 + 32'(u*256 + seq[u]), u*8 + seq[u]);
                end
            end else begin
                acc = '0;
                idle();
            end
            tick();
            for (int u = 0; u < 3; u++) begin
                if (acc[u]) seq[u]++;
            end
            if (k <= 4) begin
                check("bp_rdy", 64'(fu_rdy), 64'(rdy_exp[k-1]));
            end
            if (k >= 2 && k <= 14) begin
                s = (k - 2) % 3;
                q = (k - 2) / 3;
                check_cdb("bp", s*8 + q, s + 1, 32'hB000_0000 + 32'(s*256 + q), s*8 + q, s);
            end else begin
                check("bp_idle_vld", 64'(cdb_vld), 64'd0);
            end
        end
        check("bp_acc0", 64'(seq[0]), 64'd5);
        check("bp_acc1", 64'(seq[1]), 64'd4);
        check("bp_acc2", 64'(seq[2]), 64'd4);

        // Flush with queues loaded; rr_ptr=1 afterwards must survive the flush.
        do_reset();
        for (int u = 0; u < 3; u++) drive(u, 20 + u, 20 + u, 32'hC0 + 32'(u), 20 + u);
        tick();
        for (int u = 0; u < 3; u++) drive(u, 23 + u, 23 + u, 32'hC3 + 32'(u), 23 + u);
        tick();
        check_cdb("fl_pre", 20, 20, 32'hC0, 20, 0);
        flush = 1'b1;
        for (int u = 0; u < 3; u++) drive(u, 26 + u, 26 + u, 32'hC6 + 32'(u), 26 + u);
        #1;
        check("fl_rdy_low", 64'(fu_rdy), 64'd0);
        tick();
        flush = 1'b0;
        idle();
        #1;
        check("fl_vld", 64'(cdb_vld), 64'd0);
        check("fl_rdy_back", 64'(fu_rdy), 64'h7);
        drive(0, 30, 30, 32'hD0, 30);
        drive(2, 31, 31, 32'hD1, 31);
        tick();
        idle();
        check("fl_no_stale", 64'(cdb_vld), 64'd0);
        tick();
        check_cdb("fl_mpy", 31, 31, 32'hD1, 31, 2);
        tick();
        check_cdb("fl_arith", 30, 30, 32'hD0, 30, 0);
        tick();
        check("fl_end_vld", 64'(cdb_vld), 64'd0);

        // Flush held for three cycles while every unit offers data.
        flush = 1'b1;
        for (int u = 0; u < 3; u++) drive(u, 28 + u, 28 + u, 32'hE0 + 32'(u), 28 + u);
        #1;
        check("flh_rdy0", 64'(fu_rdy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("flh_vld", 64'(cdb_vld), 64'd0);
            check("flh_rdy", 64'(fu_rdy),  64'd0);
        end
        flush = 1'b0;
        idle();
        #1;
        check("flh_rdy_back", 64'(fu_rdy), 64'h7);
        tick();
        check("flh_after_vld", 64'(cdb_vld), 64'd0);

        // Async reset mid-stream (rr_ptr=1 going in, so logic wins first).
        for (int u = 0; u < 3; u++) drive(u, 1 + u, 1, 32'hF0 + 32'(u), 1);
        tick();
        for (int u = 0; u < 3; u++) drive(u, 4 + u, 2, 32'hF3 + 32'(u), 2);
        tick();
        idle();
        check("ar_pre_vld", 64'(cdb_vld), 64'd1);
        check("ar_pre_src", 64'(cdb_src), 64'd1);
        check("ar_pre_rdy", 64'(fu_rdy),  64'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_vld_now", 64'(cdb_vld), 64'd0);
        check("ar_rdy_now", 64'(fu_rdy),  64'd0);
        check("ar_tag_now", 64'(cdb_tag), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_rel_rdy", 64'(fu_rdy), 64'h7);
        drive(0, 17, 9, 32'h1234_5678, 17);
        drive(2, 18, 6, 32'h8765_4321, 18);
        tick();
        idle();
        check("ar_gap_vld", 64'(cdb_vld), 64'd0);
        tick();
        check_cdb("ar_arith", 17, 9, 32'h1234_5678, 17, 0);
        tick();
        check_cdb("ar_mpy", 18, 6, 32'h8765_4321, 18, 2);
        tick();
        check("ar_end_vld", 64'(cdb_vld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
